dlx_issue_scoreboard: RTL and testbench

Issue-stage hazard controller for the DLX pipeline. It tracks in-flight register writes in a pending-write scoreboard and sequences the shared multi-cycle multiply unit. It produces the ID-stage stall and the WB-to-ID bypass selects. It sits beside the decode stage and consumes the same rs1/rs2/rd/we fields that the per-stage hazard comparators use.

---
 rtl/dlx_pkg.sv | 16 +
 rtl/reg_pending_table.sv | 47 ++++
 rtl/dlx_issue_scoreboard.sv | 126 ++++++++++++
 tb/tb_dlx_issue_scoreboard.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/dlx_pkg.sv
// Shared DLX issue-stage definitions: register-file geometry, multiply latency
// and the multiply sequencer state encoding.
package dlx_pkg;

    localparam int REG_W            = 5;
    localparam int NREG             = 32;
    localparam int MULT_LAT_DEFAULT = 4;
    localparam int CNT_W            = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } mult_state_e;

endpackage

// File: rtl/reg_pending_table.sv
// One pending-write bit per architectural register, with two source read
// ports and a destination (WAW) read port. A set beats a clear on the same bit.
module reg_pending_table
#(
    parameter int NREG  = dlx_pkg::NREG,
    parameter int REG_W = dlx_pkg::REG_W
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set_en_i,
    input  logic [REG_W-1:0] set_idx_i,
    input  logic             clr_en_i,
    input  logic [REG_W-1:0] clr_idx_i,
    input  logic [REG_W-1:0] rd_a_idx_i,
    input  logic [REG_W-1:0] rd_b_idx_i,
    input  logic [REG_W-1:0] rd_w_idx_i,
    output logic             rd_a_o,
    output logic             rd_b_o,
    output logic             rd_w_o
);

    logic [NREG-1:0] pend_q;
    logic [NREG-1:0] pend_d;

    // NOTE: always_comb assigns every target a default first, so no path leaves
    // a bit unassigned and no latch is inferred.
    always_comb begin
        pend_d = pend_q;
        if (clr_en_i) pend_d[clr_idx_i] = 1'b0;
        // Applied after the clear so a new writer survives the old writer's retirement.
        if (set_en_i) pend_d[set_idx_i] = 1'b1;
        pend_d[0] = 1'b0;
    end

    // NOTE: the table is only NREG flops, not a RAM, so it is reset explicitly;
    // an in-flight bit surviving reset would stall the pipeline forever.
    always_ff @(posedge clk) begin
        if (!rst_n) pend_q <= '0;
        else        pend_q <= pend_d;
    end

    assign rd_a_o = pend_q[rd_a_idx_i];
    assign rd_b_o = pend_q[rd_b_idx_i];
    assign rd_w_o = pend_q[rd_w_idx_i];

endmodule

// File: rtl/dlx_issue_scoreboard.sv
// DLX issue-stage hazard controller: RAW/WAW/structural stall, WB->ID bypass
// selects, and the sequencer for the shared multi-cycle multiplier.
module dlx_issue_scoreboard
#(
    parameter int NREG     = dlx_pkg::NREG,
    parameter int MULT_LAT = dlx_pkg::MULT_LAT_DEFAULT
)
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      issue_valid,
    input  logic [dlx_pkg::REG_W-1:0] rs1_id,
    input  logic [dlx_pkg::REG_W-1:0] rs2_id,
    input  logic                      use_rs1,
    input  logic                      use_rs2,
    input  logic [dlx_pkg::REG_W-1:0] rd_id,
    input  logic                      we_id,
    input  logic                      mult_id,
    input  logic [dlx_pkg::REG_W-1:0] rd_wb,
    input  logic                      we_wb,
    input  logic                      wb_grant,
    output logic                      stall_id,
    output logic                      bypass_rs1,
    output logic                      bypass_rs2,
    output logic                      mult_start,
    output logic                      mult_done,
    output logic [dlx_pkg::REG_W-1:0] mult_rd,
    output logic                      mult_busy
);

    import dlx_pkg::*;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULT_LAT - 1);

    mult_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [REG_W-1:0] mult_rd_q, mult_rd_d;

    logic issue_fire;
    logic pend_rs1, pend_rs2, pend_rd;
    logic clr_rs1, clr_rs2, clr_rd;
    logic raw_rs1, raw_rs2, waw_rd, struct_mult;

    reg_pending_table #(
        .NREG  (NREG),
        .REG_W (REG_W)
    ) u_pend (
        .clk        (clk),
        .rst_n      (rst_n),
        .set_en_i   (issue_fire & we_id & (rd_id != '0)),
        .set_idx_i  (rd_id),
        .clr_en_i   (we_wb),
        .clr_idx_i  (rd_wb),
        .rd_a_idx_i (rs1_id),
        .rd_b_idx_i (rs2_id),
        .rd_w_idx_i (rd_id),
        .rd_a_o     (pend_rs1),
        .rd_b_o     (pend_rs2),
        .rd_w_o     (pend_rd)
    );

    // A register retiring in WB this cycle is not a hazard: its value is bypassed.
    assign clr_rs1 = we_wb & (rd_wb == rs1_id);
    assign clr_rs2 = we_wb & (rd_wb == rs2_id);
    assign clr_rd  = we_wb & (rd_wb == rd_id);

    assign raw_rs1     = use_rs1 & pend_rs1 & ~clr_rs1;
    assign raw_rs2     = use_rs2 & pend_rs2 & ~clr_rs2;
    assign waw_rd      = we_id   & pend_rd  & ~clr_rd;
    assign struct_mult = mult_id & (state_q != IDLE);

    assign stall_id   = issue_valid & (raw_rs1 | raw_rs2 | waw_rd | struct_mult);
    assign issue_fire = issue_valid & ~stall_id;

    assign bypass_rs1 = use_rs1 & we_wb & (rd_wb == rs1_id) & (rs1_id != '0);
    assign bypass_rs2 = use_rs2 & we_wb & (rd_wb == rs2_id) & (rs2_id != '0);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mult_rd_d = mult_rd_q;
        case (state_q)
            IDLE: begin
                if (issue_fire & mult_id) begin
                    state_d   = BUSY;
                    cnt_d     = CNT_LOAD;
                    mult_rd_d = rd_id;
                end
            end
            BUSY: begin
                // Leave BUSY on the decrement that brings cnt to zero, so the
                // result is ready exactly MULT_LAT cycles after issue.
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                if (wb_grant) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            mult_rd_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mult_rd_q <= mult_rd_d;
        end
    end

    assign mult_start = issue_fire & mult_id & (state_q == IDLE);
    assign mult_done  = (state_q == DONE);
    assign mult_busy  = (state_q != IDLE);
    assign mult_rd    = mult_rd_q;

endmodule

// File: tb/tb_dlx_issue_scoreboard.sv
// Directed bench for dlx_issue_scoreboard: hazards, bypass, register 0,
// set/clear collision, multiply sequencing and mid-multiply reset.
module tb_dlx_issue_scoreboard;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       issue_valid;
    logic [4:0] rs1_id, rs2_id, rd_id, rd_wb, mult_rd;
    logic       use_rs1, use_rs2, we_id, mult_id, we_wb, wb_grant;
    logic       stall_id, bypass_rs1, bypass_rs2, mult_start, mult_done, mult_busy;

    int n_checks = 0;
    int n_errors = 0;

    dlx_issue_scoreboard #(.NREG(32), .MULT_LAT(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issue_valid),
        .rs1_id      (rs1_id),
        .rs2_id      (rs2_id),
        .use_rs1     (use_rs1),
        .use_rs2     (use_rs2),
        .rd_id       (rd_id),
        .we_id       (we_id),
        .mult_id     (mult_id),
        .rd_wb       (rd_wb),
        .we_wb       (we_wb),
        .wb_grant    (wb_grant),
        .stall_id    (stall_id),
        .bypass_rs1  (bypass_rs1),
        .bypass_rs2  (bypass_rs2),
        .mult_start  (mult_start),
        .mult_done   (mult_done),
        .mult_rd     (mult_rd),
        .mult_busy   (mult_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        issue_valid = 0; use_rs1 = 0; use_rs2 = 0; we_id = 0; mult_id = 0;
        rs1_id = 0; rs2_id = 0; rd_id = 0; rd_wb = 0; we_wb = 0; wb_grant = 0;
    endtask

    // Inputs change 1 ns after the rising edge; checks run 1 ns later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic issue(input logic [4:0] rd, input logic we, input logic mul);
        issue_valid = 1; rd_id = rd; we_id = we; mult_id = mul;
    endtask

    task automatic wb(input logic [4:0] rd);
        we_wb = 1; rd_wb = rd;
    endtask

    initial begin
        rst_n = 0;
        idle_inputs();
        next_cycle();
        next_cycle();
        rst_n = 1;
        settle();
        check("rst_stall",  32'(stall_id),   0);
        check("rst_byp1",   32'(bypass_rs1), 0);
        check("rst_byp2",   32'(bypass_rs2), 0);
        check("rst_start",  32'(mult_start), 0);
        check("rst_done",   32'(mult_done),  0);
        check("rst_busy",   32'(mult_busy),  0);
        check("rst_multrd", 32'(mult_rd),    0);

        // RAW on r5, cleared through writeback with bypass
        next_cycle(); idle_inputs();
        issue(5, 1, 0); settle();
        check("raw_issue_stall", 32'(stall_id), 0);
        next_cycle(); idle_inputs();
        issue_valid = 1; use_rs1 = 1; rs1_id = 5; settle();
        check("raw_stall",  32'(stall_id),   1);
        check("raw_nobyp",  32'(bypass_rs1), 0);
        next_cycle();
        wb(5); settle();
        check("raw_wb_stall", 32'(stall_id),   0);
        check("raw_wb_byp",   32'(bypass_rs1), 1);
        check("raw_wb_byp2",  32'(bypass_rs2), 0);
        next_cycle();
        we_wb = 0; settle();
        check("raw_cleared", 32'(stall_id),   0);
        check("raw_nobyp2",  32'(bypass_rs1), 0);

        // Register 0 never becomes pending and never bypasses
        next_cycle(); idle_inputs();
        issue(0, 1, 0); settle();
        check("r0_issue", 32'(stall_id), 0);
        next_cycle(); idle_inputs();
        issue_valid = 1; use_rs2 = 1; rs2_id = 0; wb(0); settle();
        check("r0_stall", 32'(stall_id),   0);
        check("r0_byp",   32'(bypass_rs2), 0);

        // WAW on r12; retirement and re-issue in one cycle keeps r12 pending
        next_cycle(); idle_inputs();
        issue(12, 1, 0); settle();
        next_cycle(); idle_inputs();
        issue(12, 1, 0); settle();
        check("waw_stall", 32'(stall_id), 1);
        next_cycle();
        wb(12); settle();
        check("waw_wb_fire", 32'(stall_id), 0);
        next_cycle(); idle_inputs();
        issue_valid = 1; use_rs2 = 1; rs2_id = 12; settle();
        check("waw_reset_pend", 32'(stall_id), 1);
        next_cycle(); idle_inputs();
        wb(12);
        next_cycle(); idle_inputs();
        issue_valid = 1; use_rs2 = 1; rs2_id = 12; settle();
        check("waw_cleared", 32'(stall_id), 0);

        // Set/clear collision on a not-yet-pending r9: set wins
        next_cycle(); idle_inputs();
        issue(9, 1, 0); wb(9); settle();
        check("coll_fire", 32'(stall_id), 0);
        next_cycle(); idle_inputs();
        issue_valid = 1; use_rs1 = 1; rs1_id = 9; settle();
        check("coll_pend", 32'(stall_id), 1);
        next_cycle(); idle_inputs();
        wb(9);

        // Stalled instruction does not set the scoreboard
        next_cycle(); idle_inputs();
        issue(3, 1, 0);
        next_cycle(); idle_inputs();
        issue(20, 1, 0); use_rs1 = 1; rs1_id = 3; settle();
        check("stalled_issue", 32'(stall_id), 1);
        next_cycle(); idle_inputs();
        wb(3);
        next_cycle(); idle_inputs();
        issue_valid = 1; use_rs1 = 1; rs1_id = 20; settle();
        check("stalled_noset", 32'(stall_id), 0);

        // Multiply to r7 at cycle t
        next_cycle(); idle_inputs();
        issue(7, 1, 1); settle();
        check("mul_t_start", 32'(mult_start), 1);
        check("mul_t_stall", 32'(stall_id),   0);
        check("mul_t_busy",  32'(mult_busy),  0);
        next_cycle(); idle_inputs();                   // t+1, grant ignored in BUSY
        wb_grant = 1; settle();
        check("mul_t1_busy",  32'(mult_busy),  1);
        check("mul_t1_start", 32'(mult_start), 0);
        check("mul_t1_rd",    32'(mult_rd),    7);
        check("mul_t1_done",  32'(mult_done),  0);
        next_cycle(); idle_inputs();                   // t+2
        issue(8, 1, 1); settle();
        check("mul_t2_struct", 32'(stall_id),   1);
        check("mul_t2_start",  32'(mult_start), 0);
        next_cycle(); idle_inputs(); settle();         // t+3
        check("mul_t3_done", 32'(mult_done), 0);
        next_cycle(); idle_inputs(); settle();         // t+4
        check("mul_t4_done", 32'(mult_done), 1);
        check("mul_t4_rd",   32'(mult_rd),   7);
        next_cycle(); idle_inputs(); settle();         // t+5
        check("mul_t5_done", 32'(mult_done), 1);
        next_cycle(); idle_inputs();                   // t+6
        issue_valid = 1; use_rs1 = 1; rs1_id = 7; settle();
        check("mul_t6_done",  32'(mult_done), 1);
        check("mul_t6_raw",   32'(stall_id),  1);
        next_cycle(); idle_inputs();                   // t+7: grant and writeback
        issue(9, 0, 1); use_rs1 = 1; rs1_id = 7; wb(7); wb_grant = 1; settle();
        check("mul_t7_done",   32'(mult_done),  1);
        check("mul_t7_struct", 32'(stall_id),   1);
        check("mul_t7_byp",    32'(bypass_rs1), 1);
        check("mul_t7_rd",     32'(mult_rd),    7);
        next_cycle(); idle_inputs();                   // t+8: IDLE, new multiply to r8
        issue(8, 1, 1); settle();
        check("mul_t8_busy",  32'(mult_busy),  0);
        check("mul_t8_done",  32'(mult_done),  0);
        check("mul_t8_stall", 32'(stall_id),   0);
        check("mul_t8_start", 32'(mult_start), 1);

        // Reset while BUSY with cnt=2 (two cycles after issue)
        next_cycle(); idle_inputs(); settle();         // t'+1, cnt=3
        check("rstm_busy", 32'(mult_busy), 1);
        next_cycle(); idle_inputs();                   // t'+2, cnt=2
        rst_n = 0;
        next_cycle();
        rst_n = 1;
        issue(8, 1, 1); use_rs1 = 1; rs1_id = 8; use_rs2 = 1; rs2_id = 8; settle();
        check("rstm_busy0",  32'(mult_busy), 0);
        check("rstm_done0",  32'(mult_done), 0);
        check("rstm_rd0",    32'(mult_rd),   0);
        check("rstm_stall0", 32'(stall_id),  0);
        idle_inputs();
        for (int i = 0; i < 6; i++) begin
            next_cycle(); settle();
            check("rstm_no_done", 32'(mult_done), 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
